// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - per-key synchroniser, debounce window and press/release event pulses
module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int                  CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [NUM_KEYS-1:0] IDLE     = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] stable_q;
  logic [NUM_KEYS-1:0] stable_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  // The output stage holds the accepted level one edge after the window
  // closes so that key_out and its event pulse change on the same edge.
  logic [NUM_KEYS-1:0] out_q;
  logic [NUM_KEYS-1:0] out_d;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] release_d;
  logic [NUM_KEYS-1:0] change;

  // Two-stage synchroniser, no logic between the stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-key window: any agreement with the accepted level restarts it; the
  // terminal compare is checked before incrementing so the counter never wraps.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Accepted level and window counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= IDLE;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A pending change is a press when the new level is the active one, a
  // release otherwise, so the two pulses can never coincide on one key.
  always_comb begin
    change    = stable_q ^ out_q;
    out_d     = stable_q;
    press_d   = change & (stable_q ^ IDLE);
    release_d = change & ~(stable_q ^ IDLE);
  end

  // Registered outputs: pin-polarity level plus one-cycle event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= IDLE;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      out_q     <= out_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_out     = out_q;
  assign key_pressed = out_q ^ IDLE;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - scoreboard bench for key_debouncer with DEBOUNCE_CYCLES=8, ACTIVE_LOW=1
module tb_key_debouncer;

  localparam int D   = 8;
  localparam int LAT = D + 3;   // push happens one cycle before edge 0, key_out moves at edge D+2

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key_out;
  logic [3:0] key_pressed;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int cyc     = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] out;
    logic [3:0] pressed;
    logic [3:0] press;
    logic [3:0] rel;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  key_debouncer #(
    .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .key_out(key_out),
    .key_pressed(key_pressed),
    .key_press(key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] o, input logic [3:0] p, input logic [3:0] pr, input logic [3:0] rl);
    exp_t e;
    e.out     = o;
    e.pressed = p;
    e.press   = pr;
    e.rel     = rl;
    e.at      = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every event pulse must match the next expected event.
  always @(negedge clk) begin
    if (reset === 1'b0 && (key_press | key_release) != 4'h0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: press=%0h release=%0h key_out=%0h (cycle %0d)",
                 key_press, key_release, key_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("event_key_out", key_out, mon_e.out);
        check("event_key_pressed", key_pressed, mon_e.pressed);
        check("event_key_press", key_press, mon_e.press);
        check("event_key_release", key_release, mon_e.rel);
        check("event_cycle", mon_e.at, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    key_raw = 4'hF;
    cycles(3);
    check("reset_key_out", key_out, 4'hF);
    check("reset_key_pressed", key_pressed, 4'h0);
    check("reset_key_press", key_press, 4'h0);
    check("reset_key_release", key_release, 4'h0);
    reset = 1'b0;
    cycles(50);
    check("idle_key_out", key_out, 4'hF);
    check("idle_pending", sb.size(), 0);

    // clean press on key 0
    key_raw = 4'hE;
    push(4'hE, 4'h1, 4'h1, 4'h0);
    cycles(LAT - 1);
    check("press_not_early", key_out, 4'hF);
    cycles(20 - (LAT - 1));
    check("press_key_out", key_out, 4'hE);
    check("press_key_pressed", key_pressed, 4'h1);
    check("press_pending", sb.size(), 0);

    // release key 0
    key_raw = 4'hF;
    push(4'hF, 4'h0, 4'h0, 4'h1);
    cycles(LAT - 1);
    check("release_not_early", key_out, 4'hE);
    cycles(20 - (LAT - 1));
    check("release_key_out", key_out, 4'hF);
    check("release_pending", sb.size(), 0);

    // bouncing press on key 1
    key_raw = 4'hD; cycles(5);
    key_raw = 4'hF; cycles(1);
    key_raw = 4'hD; cycles(5);
    key_raw = 4'hF; cycles(1);
    key_raw = 4'hD;
    push(4'hD, 4'h2, 4'h2, 4'h0);
    cycles(LAT - 1);
    check("bounce_not_early", key_out, 4'hF);
    cycles(20 - (LAT - 1));
    check("bounce_key_out", key_out, 4'hD);
    check("bounce_pending", sb.size(), 0);
    key_raw = 4'hF;
    push(4'hF, 4'h0, 4'h0, 4'h2);
    cycles(20);
    check("bounce_release_pending", sb.size(), 0);

    // key 3 toggling every cycle never settles
    for (int i = 0; i < 30; i++) begin
      key_raw[3] = ~key_raw[3];
      cycles(1);
    end
    key_raw = 4'hF;
    cycles(20);
    check("toggle_key_out", key_out, 4'hF);

    // pulse one cycle shorter than the window is filtered
    key_raw = 4'hE;
    cycles(D - 1);
    key_raw = 4'hF;
    cycles(20);
    check("short_key_out", key_out, 4'hF);
    check("short_pending", sb.size(), 0);

    // simultaneous press on keys 1 and 3
    key_raw = 4'h5;
    push(4'h5, 4'hA, 4'hA, 4'h0);
    cycles(20);
    check("multi_key_out", key_out, 4'h5);
    check("multi_key_pressed", key_pressed, 4'hA);
    check("multi_pending", sb.size(), 0);

    // reset while keys are held clears outputs immediately, no release pulse
    reset = 1'b1;
    #1;
    check("async_reset_key_out", key_out, 4'hF);
    check("async_reset_key_pressed", key_pressed, 4'h0);
    key_raw = 4'hF;
    cycles(2);
    reset = 1'b0;
    cycles(20);
    check("after_reset_key_out", key_out, 4'hF);

    // reset four cycles into a press window on key 2, key held throughout
    key_raw = 4'hB;
    cycles(4);
    reset = 1'b1;
    #1;
    check("mid_reset_key_out", key_out, 4'hF);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check("mid_reset_key_press", key_press, 4'h0);
    end
    reset = 1'b0;
    push(4'hB, 4'h4, 4'h4, 4'h0);
    cycles(LAT - 1);
    check("reset_press_not_early", key_out, 4'hF);
    cycles(20 - (LAT - 1));
    check("reset_press_key_out", key_out, 4'hB);
    check("reset_press_pending", sb.size(), 0);
    key_raw = 4'hF;
    push(4'hF, 4'h0, 4'h0, 4'h4);
    cycles(20);
    check("final_key_out", key_out, 4'hF);
    check("final_pending", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
